// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared FSM encoding, BCD constants and display helper.
// Revision : 1.0
// ============================================================================
`default_nettype none

package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } sw_state_t;

   localparam logic [3:0] BCD_MAX    = 4'd9;
   localparam int         NUM_DIGITS = 4;

   function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
      digit_onehot = 4'b0001 << idx;
   endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// ============================================================================
// Module   : bcd_digit
// Purpose  : Single decimal counter stage with ripple carry to the next stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   // Carry is combinational so the whole chain rolls over on one edge.
   assign carry = inc & (q == BCD_MAX);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         q <= 4'd0;
      end else if (inc) begin
         q <= (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Four-digit BCD stopwatch with run/pause FSM and multiplexed scan.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 10,
   parameter int SCAN_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        clear,
   output logic [15:0] count,
   output logic        running,
   output logic        overflow,
   output logic [3:0]  digit_sel,
   output logic [3:0]  digit_bcd
);

   localparam int TW  = $clog2(TICK_DIV);
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [TW-1:0]  c_tick_last = TW'(TICK_DIV - 1);
   localparam logic [SCW-1:0] c_scan_last = SCW'(SCAN_DIV - 1);

   sw_state_t              r_state;
   sw_state_t              w_state_nxt;
   logic [TW-1:0]          r_presc;
   logic                   w_tick;
   logic [NUM_DIGITS:0]    w_inc;
   logic [15:0]            w_count;
   logic                   r_overflow;
   logic [SCW-1:0]         r_scan_cnt;
   logic [1:0]             r_scan_idx;

   // ------------------------------------------------------------------
   // Run/pause state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = IDLE;
      end else if (start_stop) begin
         case (r_state)
            IDLE:    w_state_nxt = RUN;
            RUN:     w_state_nxt = PAUSE;
            PAUSE:   w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
         endcase
      end else if ((r_state != IDLE) && (r_state != RUN) && (r_state != PAUSE)) begin
         w_state_nxt = IDLE;
      end
   end

   assign running = (r_state == RUN);

   // ------------------------------------------------------------------
   // Prescaler: free-runs in RUN, frozen in PAUSE so a resume keeps its phase
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_presc <= '0;
      end else if (r_state == RUN) begin
         r_presc <= (r_presc == c_tick_last) ? '0 : r_presc + 1'b1;
      end else if (r_state == IDLE) begin
         r_presc <= '0;
      end
   end

   assign w_tick = (r_state == RUN) && (r_presc == c_tick_last);

   // ------------------------------------------------------------------
   // BCD digit chain
   // ------------------------------------------------------------------
   assign w_inc[0] = w_tick;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (clear),
            .inc   (w_inc[gi]),
            .q     (w_count[gi*4 +: 4]),
            .carry (w_inc[gi+1])
         );
      end
   endgenerate

   assign count = w_count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_overflow <= 1'b0;
      end else if (w_inc[NUM_DIGITS]) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;

   // ------------------------------------------------------------------
   // Display scan: independent of FSM state, only rst restarts it
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_scan_cnt <= '0;
         r_scan_idx <= 2'd0;
         digit_sel  <= 4'b0001;
         digit_bcd  <= 4'd0;
      end else begin
         if (r_scan_cnt == c_scan_last) begin
            r_scan_cnt <= '0;
            r_scan_idx <= r_scan_idx + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         digit_sel <= digit_onehot(r_scan_idx);
         digit_bcd <= w_count[{r_scan_idx, 2'b00} +: 4];
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed self-checking bench for stopwatch_ctrl (TICK_DIV=4, SCAN_DIV=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   logic        clk;
   logic        rst;
   logic        start_stop;
   logic        clear;
   logic [15:0] count;
   logic        running;
   logic        overflow;
   logic [3:0]  digit_sel;
   logic [3:0]  digit_bcd;

   int vectors     = 0;
   int miscompares = 0;
   logic mon_en    = 1'b0;

   stopwatch_ctrl #(
      .TICK_DIV (4),
      .SCAN_DIV (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_stop (start_stop),
      .clear      (clear),
      .count      (count),
      .running    (running),
      .overflow   (overflow),
      .digit_sel  (digit_sel),
      .digit_bcd  (digit_bcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Continuous invariants: every digit is decimal, select is one-hot.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int i = 0; i < 4; i++) begin
            if (count[i*4 +: 4] > 4'd9) begin
               miscompares++;
               $display("FAIL digit_range[%0d]: got %h want <=9", i, count[i*4 +: 4]);
            end
         end
         if (digit_bcd > 4'd9) begin
            miscompares++;
            $display("FAIL digit_bcd_range: got %h want <=9", digit_bcd);
         end
         if (!$onehot(digit_sel)) begin
            miscompares++;
            $display("FAIL digit_sel_onehot: got %b want one-hot", digit_sel);
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
   endtask

   task automatic pulse_clr();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      start_stop = 1'b1;
      clear      = 1'b0;
      run(3);
      vectors++;
      if (count !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_core: got count=%h run=%b ovf=%b want 0000/0/0", count, running, overflow);
      end
      vectors++;
      if (digit_sel !== 4'b0001 || digit_bcd !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_scan: got sel=%b bcd=%h want 0001/0", digit_sel, digit_bcd);
      end
      rst        = 1'b0;
      start_stop = 1'b0;
      mon_en     = 1'b1;
      run(2);
      vectors++;
      if (running !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: got running=%b want 0", running);
      end
   endtask

   task automatic test_run();
      pulse_ss();
      vectors++;
      if (running !== 1'b1 || count !== 16'h0000) begin
         miscompares++;
         $display("FAIL run_enter: got run=%b count=%h want 1/0000", running, count);
      end
      run(3);
      vectors++;
      if (count !== 16'h0000) begin
         miscompares++;
         $display("FAIL run_first_tick_early: got %h want 0000", count);
      end
      run(1);
      vectors++;
      if (count !== 16'h0001) begin
         miscompares++;
         $display("FAIL run_first_tick: got %h want 0001", count);
      end
      run(36);
      vectors++;
      if (count !== 16'h0010 || running !== 1'b1) begin
         miscompares++;
         $display("FAIL run_40: got count=%h run=%b want 0010/1", count, running);
      end
   endtask

   task automatic test_clear_midrun();
      run(39);
      vectors++;
      if (count !== 16'h0019) begin
         miscompares++;
         $display("FAIL pre_clear_count: got %h want 0019", count);
      end
      pulse_clr();
      vectors++;
      if (count !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_midrun: got count=%h run=%b ovf=%b want 0000/0/0", count, running, overflow);
      end
      run(5);
      vectors++;
      if (count !== 16'h0000 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_hold: got count=%h run=%b want 0000/0", count, running);
      end
   endtask

   task automatic test_back_to_back();
      pulse_ss();
      run(3);
      pulse_ss();
      vectors++;
      if (count !== 16'h0001 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL ss_on_tick: got count=%h run=%b want 0001/0", count, running);
      end
      run(10);
      vectors++;
      if (count !== 16'h0001) begin
         miscompares++;
         $display("FAIL ss_on_tick_hold: got %h want 0001", count);
      end
      pulse_clr();
   endtask

   task automatic test_pause();
      pulse_ss();
      run(13);
      pulse_ss();
      vectors++;
      if (count !== 16'h0003 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_enter: got count=%h run=%b want 0003/0", count, running);
      end
      run(50);
      vectors++;
      if (count !== 16'h0003) begin
         miscompares++;
         $display("FAIL pause_hold: got %h want 0003", count);
      end
      pulse_ss();
      vectors++;
      if (count !== 16'h0003 || running !== 1'b1) begin
         miscompares++;
         $display("FAIL resume_0: got count=%h run=%b want 0003/1", count, running);
      end
      run(1);
      vectors++;
      if (count !== 16'h0003) begin
         miscompares++;
         $display("FAIL resume_1: got %h want 0003", count);
      end
      run(1);
      vectors++;
      if (count !== 16'h0004) begin
         miscompares++;
         $display("FAIL resume_2: got %h want 0004", count);
      end
      pulse_clr();
   endtask

   task automatic test_carry();
      pulse_ss();
      run(396);
      vectors++;
      if (count !== 16'h0099) begin
         miscompares++;
         $display("FAIL carry_pre: got %h want 0099", count);
      end
      run(4);
      vectors++;
      if (count !== 16'h0100) begin
         miscompares++;
         $display("FAIL carry_two_digits: got %h want 0100", count);
      end
      run(4536);
      vectors++;
      if (count !== 16'h1234) begin
         miscompares++;
         $display("FAIL count_1234: got %h want 1234", count);
      end
      pulse_ss();
      vectors++;
      if (count !== 16'h1234 || running !== 1'b0) begin
         miscompares++;
         $display("FAIL pause_1234: got count=%h run=%b want 1234/0", count, running);
      end
   endtask

   task automatic test_scan();
      logic [3:0] exp_bcd [4];
      logic [3:0] prev_sel;
      logic [3:0] exp_sel;
      bit         found;
      exp_bcd  = '{4'd4, 4'd3, 4'd2, 4'd1};
      found    = 1'b0;
      prev_sel = digit_sel;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (digit_sel == 4'b0001 && prev_sel == 4'b1000) found = 1'b1;
         else prev_sel = digit_sel;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL scan_align: got sel=%b want 1000->0001 within 20 cycles", digit_sel);
      end else begin
         for (int i = 0; i < 8; i++) begin
            exp_sel = 4'b0001 << (i / 2);
            vectors++;
            if (digit_sel !== exp_sel || digit_bcd !== exp_bcd[i/2]) begin
               miscompares++;
               $display("FAIL scan_cycle%0d: got sel=%b bcd=%h want %b/%h",
                        i, digit_sel, digit_bcd, exp_sel, exp_bcd[i/2]);
            end
            @(negedge clk);
         end
      end
   endtask

   task automatic test_overflow();
      pulse_ss();
      run(35059);
      vectors++;
      if (count !== 16'h9999 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL pre_wrap: got count=%h ovf=%b want 9999/0", count, overflow);
      end
      run(3);
      vectors++;
      if (count !== 16'h9999) begin
         miscompares++;
         $display("FAIL pre_wrap_hold: got %h want 9999", count);
      end
      run(1);
      vectors++;
      if (count !== 16'h0000 || overflow !== 1'b1 || running !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap: got count=%h ovf=%b run=%b want 0000/1/1", count, overflow, running);
      end
      run(4);
      vectors++;
      if (count !== 16'h0001 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got count=%h ovf=%b want 0001/1", count, overflow);
      end
   endtask

   task automatic test_clear_priority();
      start_stop = 1'b1;
      clear      = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
      clear      = 1'b0;
      vectors++;
      if (count !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_vs_ss: got count=%h run=%b ovf=%b want 0000/0/0", count, running, overflow);
      end
      run(3);
      vectors++;
      if (running !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_vs_ss_idle: got running=%b want 0", running);
      end
   endtask

   task automatic test_rst_midrun();
      pulse_ss();
      run(10);
      vectors++;
      if (count !== 16'h0002 || running !== 1'b1) begin
         miscompares++;
         $display("FAIL pre_rst: got count=%h run=%b want 0002/1", count, running);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++;
      if (count !== 16'h0000 || running !== 1'b0 || overflow !== 1'b0 ||
          digit_sel !== 4'b0001 || digit_bcd !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_midrun: got count=%h run=%b ovf=%b sel=%b bcd=%h want 0000/0/0/0001/0",
                  count, running, overflow, digit_sel, digit_bcd);
      end
   endtask

   initial begin
      rst        = 1'b1;
      start_stop = 1'b0;
      clear      = 1'b0;
      test_reset();
      test_run();
      test_clear_midrun();
      test_back_to_back();
      test_pause();
      test_carry();
      test_scan();
      test_overflow();
      test_clear_priority();
      test_rst_midrun();
      run(2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
